// File: rtl/img_ctrl_pkg.sv
// Shared definitions for the image-window controller.
//   - command codes carried on cmd
//   - controller state enum
//   - bit positions of the window pixels in the ALU write-enable vector
package img_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_CCW   = 4'd8;
  localparam logic [3:0] CMD_CW    = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TR = 1;
  localparam int unsigned WIN_BL = 2;
  localparam int unsigned WIN_BR = 3;

endpackage

// File: rtl/img_window_alu.sv
// Combinational 2x2 window operator.
// Ports:
//   tl, tr, bl, br          current window pixels
//   cmd                     command code
//   tl_new .. br_new        replacement pixels (old values when not written)
//   we[3:0]                 per-pixel write enable, indexed by WIN_TL..WIN_BR
module img_window_alu
  import img_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  input  logic [3:0]        cmd,
  output logic [DATA_W-1:0] tl_new,
  output logic [DATA_W-1:0] tr_new,
  output logic [DATA_W-1:0] bl_new,
  output logic [DATA_W-1:0] br_new,
  output logic [3:0]        we
);

  logic [DATA_W-1:0] max_top, max_bot, max_all;
  logic [DATA_W-1:0] min_top, min_bot, min_all;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] avg;

  assign max_top = (tl > tr) ? tl : tr;
  assign max_bot = (bl > br) ? bl : br;
  assign max_all = (max_top > max_bot) ? max_top : max_bot;
  assign min_top = (tl < tr) ? tl : tr;
  assign min_bot = (bl < br) ? bl : br;
  assign min_all = (min_top < min_bot) ? min_top : min_bot;

  // Two guard bits keep the four-way sum exact.
  assign sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
  assign avg = DATA_W'(sum >> 2);

  always_comb begin
    tl_new = tl;
    tr_new = tr;
    bl_new = bl;
    br_new = br;
    we     = 4'b0000;
    case (cmd)
      CMD_MAX: begin
        tl_new = max_all;
        tr_new = max_all;
        bl_new = max_all;
        br_new = max_all;
        we     = 4'b1111;
      end
      CMD_MIN: begin
        tl_new = min_all;
        tr_new = min_all;
        bl_new = min_all;
        br_new = min_all;
        we     = 4'b1111;
      end
      CMD_AVG: begin
        tl_new = avg;
        tr_new = avg;
        bl_new = avg;
        br_new = avg;
        we     = 4'b1111;
      end
      CMD_CCW: begin
        tl_new = tr;
        tr_new = br;
        br_new = bl;
        bl_new = tl;
        we     = 4'b1111;
      end
      CMD_CW: begin
        tl_new = bl;
        bl_new = br;
        br_new = tr;
        tr_new = tl;
        we     = 4'b1111;
      end
      CMD_MIRX: begin
        tl_new = bl;
        bl_new = tl;
        tr_new = br;
        br_new = tr;
        we     = 4'b1111;
      end
      CMD_MIRY: begin
        tl_new = tr;
        tr_new = tl;
        bl_new = br;
        br_new = bl;
        we     = 4'b1111;
      end
      default: ;  // write, shifts and no-ops leave the pixels alone
    endcase
  end

endmodule

// File: rtl/img_window_ctrl.sv
// Image-window controller: loads an IMG_W x IMG_H image from ROM into a local buffer,
// runs 2x2 window commands around a movable anchor, then streams the buffer to RAM.
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   cmd, cmd_valid               command code and strobe (accepted only when busy=0)
//   rom_q, rom_rd, rom_a         ROM read port, data one cycle after address
//   ram_valid, ram_a, ram_d      RAM write port
//   busy                         command not accepted while high
//   done                         image written out; held until reset
module img_window_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [3:0]                           cmd,
  input  logic                                 cmd_valid,
  input  logic [DATA_W-1:0]                    rom_q,
  output logic                                 rom_rd,
  output logic [$clog2(IMG_W*IMG_H)-1:0]       rom_a,
  output logic                                 ram_valid,
  output logic [$clog2(IMG_W*IMG_H)-1:0]       ram_a,
  output logic [DATA_W-1:0]                    ram_d,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;  // load counter must reach N
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] buf_q [N];

  logic [AW-1:0]     addr_tl, addr_tr, addr_bl, addr_br;
  logic [DATA_W-1:0] tl_new, tr_new, bl_new, br_new;
  logic [3:0]        win_we;
  logic              load_active;

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return AW'(int'(py) * int'(IMG_W) + int'(px));
  endfunction

  // Anchor is the bottom-right pixel, so the window extends up and left.
  assign addr_tl = pix_addr(x_q - XW'(1), y_q - YW'(1));
  assign addr_tr = pix_addr(x_q,          y_q - YW'(1));
  assign addr_bl = pix_addr(x_q - XW'(1), y_q);
  assign addr_br = pix_addr(x_q,          y_q);

  img_window_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .tl     (buf_q[addr_tl]),
    .tr     (buf_q[addr_tr]),
    .bl     (buf_q[addr_bl]),
    .br     (buf_q[addr_br]),
    .cmd    (cmd_q),
    .tl_new (tl_new),
    .tr_new (tr_new),
    .bl_new (bl_new),
    .br_new (br_new),
    .we     (win_we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      x_q     <= XW'(IMG_W / 2);
      y_q     <= YW'(IMG_H / 2);
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_LOAD: begin
        // cnt runs 0..N; the extra cycle captures the last ROM word.
        if (cnt_q == CW'(N)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd;
          if (cmd == CMD_WRITE) begin
            state_d = S_WRITE;
            cnt_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (cmd_q)
          CMD_UP:    if (y_q > YW'(1))         y_d = y_q - YW'(1);
          CMD_DOWN:  if (y_q < YW'(IMG_H - 1)) y_d = y_q + YW'(1);
          CMD_LEFT:  if (x_q > XW'(1))         x_d = x_q - XW'(1);
          CMD_RIGHT: if (x_q < XW'(IMG_W - 1)) x_d = x_q + XW'(1);
          default: ;
        endcase
      end
      S_WRITE: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: ;
      default: state_d = S_LOAD;
    endcase
  end

  assign load_active = (state_q == S_LOAD) && (cnt_q < CW'(N));

  always_comb begin
    rom_rd    = load_active;
    rom_a     = '0;
    ram_valid = (state_q == S_WRITE);
    ram_a     = '0;
    ram_d     = '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    if (state_q == S_LOAD) begin
      rom_a = load_active ? cnt_q[AW-1:0] : AW'(N - 1);
    end
    // In DONE the counter stays at N-1, so the last write is held on the port.
    if (state_q == S_WRITE || state_q == S_DONE) begin
      ram_a = cnt_q[AW-1:0];
      ram_d = buf_q[cnt_q[AW-1:0]];
    end
  end

  // Buffer has no reset; a reload overwrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && cnt_q != '0) begin
      buf_q[AW'(cnt_q - CW'(1))] <= rom_q;
    end
    if (state_q == S_EXEC) begin
      if (win_we[WIN_TL]) buf_q[addr_tl] <= tl_new;
      if (win_we[WIN_TR]) buf_q[addr_tr] <= tr_new;
      if (win_we[WIN_BL]) buf_q[addr_bl] <= bl_new;
      if (win_we[WIN_BR]) buf_q[addr_br] <= br_new;
    end
  end

endmodule

// File: tb/tb_img_window_ctrl.sv
module tb_img_window_ctrl;
  import img_ctrl_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default 8x8x8 instance
  logic       reset = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] rom_q;
  logic       rom_rd;
  logic [5:0] rom_a;
  logic       ram_valid;
  logic [5:0] ram_a;
  logic [7:0] ram_d;
  logic       busy, done;

  // 16x4x10 instance
  logic       reset1 = 1'b0;
  logic [3:0] cmd1;
  logic       cmd_valid1;
  logic [9:0] rom1_q;
  logic       rom1_rd;
  logic [5:0] rom1_a;
  logic       ram1_valid;
  logic [5:0] ram1_a;
  logic [9:0] ram1_d;
  logic       busy1, done1;

  img_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .rom_q     (rom_q),
    .rom_rd    (rom_rd),
    .rom_a     (rom_a),
    .ram_valid (ram_valid),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .busy      (busy),
    .done      (done)
  );

  img_window_ctrl #(.DATA_W(10), .IMG_W(16), .IMG_H(4)) dut1 (
    .clk       (clk),
    .reset     (reset1),
    .cmd       (cmd1),
    .cmd_valid (cmd_valid1),
    .rom_q     (rom1_q),
    .rom_rd    (rom1_rd),
    .rom_a     (rom1_a),
    .ram_valid (ram1_valid),
    .ram_a     (ram1_a),
    .ram_d     (ram1_d),
    .busy      (busy1),
    .done      (done1)
  );

  // ROMs: one-cycle read latency
  always @(posedge clk) begin
    rom_q  <= {2'b00, rom_a};
    rom1_q <= 10'(rom1_a) + 10'd960;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    #1;
    if (chk) begin
      check("rst_rom_rd", 32'(rom_rd), 1);
      check("rst_rom_a", 32'(rom_a), 0);
      check("rst_ram_valid", 32'(ram_valid), 0);
      check("rst_ram_a", 32'(ram_a), 0);
      check("rst_ram_d", 32'(ram_d), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_done", 32'(done), 0);
    end
  endtask

  task automatic do_load(input bit chk);
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k <= N + 1; k++) begin
      if (chk) begin
        if (k < N) begin
          check($sformatf("load%0d_rd", k), 32'(rom_rd), 1);
          check($sformatf("load%0d_a", k), 32'(rom_a), 32'(k));
        end else if (k == N) begin
          check("load_end_rd", 32'(rom_rd), 0);
          check("load_end_busy", 32'(busy), 1);
        end else begin
          check("load_busy_fall", 32'(busy), 0);
        end
      end
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8; i++) begin
      if (busy == 1'b0) break;
      tick();
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic apply_cmd(input logic [3:0] c);
    wait_idle();
    cmd       = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check($sformatf("cmd%0d_busy_exec", c), 32'(busy), 1);
    tick();
    check($sformatf("cmd%0d_busy_back", c), 32'(busy), 0);
  endtask

  task automatic apply_cmd1(input logic [3:0] c);
    for (int i = 0; i < 8; i++) begin
      if (busy1 == 1'b0) break;
      tick();
    end
    check("d1_wait_idle", 32'(busy1), 0);
    cmd1       = c;
    cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    check("d1_busy_exec", 32'(busy1), 1);
    tick();
    check("d1_busy_back", 32'(busy1), 0);
  endtask

  typedef struct {
    bit         fresh;
    logic [3:0] c;
    int         x;
    int         y;
    int         p27;
    int         p28;
    int         p35;
    int         p36;
  } vec_t;

  vec_t tv[20];
  int   exp_img[N];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, CMD_MAX,   4, 4, 36, 36, 36, 36};
    tv[1]  = '{1'b1, CMD_AVG,   4, 4, 31, 31, 31, 31};
    tv[2]  = '{1'b1, CMD_MIN,   4, 4, 27, 27, 27, 27};
    tv[3]  = '{1'b1, CMD_CW,    4, 4, 35, 27, 36, 28};
    tv[4]  = '{1'b0, CMD_CCW,   4, 4, 27, 28, 35, 36};
    tv[5]  = '{1'b0, CMD_MIRX,  4, 4, 35, 36, 27, 28};
    tv[6]  = '{1'b0, CMD_MIRY,  4, 4, 36, 35, 28, 27};
    tv[7]  = '{1'b0, 4'd15,     4, 4, 36, 35, 28, 27};
    tv[8]  = '{1'b0, CMD_UP,    4, 3, 36, 35, 28, 27};
    tv[9]  = '{1'b0, CMD_UP,    4, 2, 36, 35, 28, 27};
    tv[10] = '{1'b0, CMD_UP,    4, 1, 36, 35, 28, 27};
    tv[11] = '{1'b0, CMD_UP,    4, 1, 36, 35, 28, 27};
    tv[12] = '{1'b0, CMD_UP,    4, 1, 36, 35, 28, 27};
    tv[13] = '{1'b0, CMD_LEFT,  3, 1, 36, 35, 28, 27};
    tv[14] = '{1'b0, CMD_LEFT,  2, 1, 36, 35, 28, 27};
    tv[15] = '{1'b0, CMD_LEFT,  1, 1, 36, 35, 28, 27};
    tv[16] = '{1'b0, CMD_LEFT,  1, 1, 36, 35, 28, 27};
    tv[17] = '{1'b0, CMD_RIGHT, 2, 1, 36, 35, 28, 27};
    tv[18] = '{1'b0, CMD_DOWN,  2, 2, 36, 35, 28, 27};
    tv[19] = '{1'b0, CMD_MAX,   2, 2, 36, 35, 28, 27};

    for (int a = 0; a < N; a++) exp_img[a] = a;
    exp_img[27] = 36; exp_img[28] = 35; exp_img[35] = 28; exp_img[36] = 27;
    exp_img[9]  = 18; exp_img[10] = 18; exp_img[17] = 18; exp_img[18] = 18;

    cmd = 4'd0; cmd_valid = 1'b0;
    cmd1 = 4'd0; cmd_valid1 = 1'b0;
    tick();
    reset1 = 1'b1;

    // Reset values and the full load sequence
    do_reset(1'b1);
    do_load(1'b1);
    check("init_x", 32'(dut.x_q), 4);
    check("init_y", 32'(dut.y_q), 4);

    // Table-driven command vectors
    for (int i = 0; i < 20; i++) begin
      if (tv[i].fresh) begin
        do_reset(1'b0);
        do_load(1'b0);
      end
      apply_cmd(tv[i].c);
      check($sformatf("v%0d_x", i), 32'(dut.x_q), 32'(tv[i].x));
      check($sformatf("v%0d_y", i), 32'(dut.y_q), 32'(tv[i].y));
      check($sformatf("v%0d_p27", i), 32'(dut.buf_q[27]), 32'(tv[i].p27));
      check($sformatf("v%0d_p28", i), 32'(dut.buf_q[28]), 32'(tv[i].p28));
      check($sformatf("v%0d_p35", i), 32'(dut.buf_q[35]), 32'(tv[i].p35));
      check($sformatf("v%0d_p36", i), 32'(dut.buf_q[36]), 32'(tv[i].p36));
    end

    // Write stream, then terminal DONE ignoring commands
    wait_idle();
    cmd = CMD_WRITE;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check($sformatf("wr%0d_valid", k), 32'(ram_valid), 1);
      check($sformatf("wr%0d_a", k), 32'(ram_a), 32'(k));
      check($sformatf("wr%0d_d", k), 32'(ram_d), 32'(exp_img[k]));
      tick();
    end
    cmd = CMD_MAX;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("done_flag", 32'(done), 1);
      check("done_busy", 32'(busy), 1);
      check("done_valid", 32'(ram_valid), 0);
      check("done_ram_a", 32'(ram_a), 63);
      tick();
    end
    cmd_valid = 1'b0;
    check("done_pix9", 32'(dut.buf_q[9]), 18);

    // Reset in the middle of a write
    do_reset(1'b0);
    do_load(1'b0);
    wait_idle();
    cmd = CMD_WRITE;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (20) tick();
    check("mw_ram_a", 32'(ram_a), 20);
    check("mw_ram_d", 32'(ram_d), 20);
    do_reset(1'b1);
    do_load(1'b1);
    check("mw_reload_x", 32'(dut.x_q), 4);

    // 16x4, 10-bit instance
    tick();
    reset1 = 1'b0;
    #1;
    for (int k = 0; k <= N + 1; k++) begin
      if (k < N) begin
        check($sformatf("d1_load%0d_a", k), 32'(rom1_a), 32'(k));
        check($sformatf("d1_load%0d_rd", k), 32'(rom1_rd), 1);
      end else if (k == N) begin
        check("d1_load_end_rd", 32'(rom1_rd), 0);
      end else begin
        check("d1_busy_fall", 32'(busy1), 0);
      end
      tick();
    end
    check("d1_init_x", 32'(dut1.x_q), 8);
    check("d1_init_y", 32'(dut1.y_q), 2);
    apply_cmd1(CMD_DOWN);
    check("d1_down1_y", 32'(dut1.y_q), 3);
    apply_cmd1(CMD_DOWN);
    check("d1_down2_y", 32'(dut1.y_q), 3);
    check("d1_down2_x", 32'(dut1.x_q), 8);
    apply_cmd1(CMD_AVG);
    check("d1_avg_p39", 32'(dut1.buf_q[39]), 1007);
    check("d1_avg_p40", 32'(dut1.buf_q[40]), 1007);
    check("d1_avg_p55", 32'(dut1.buf_q[55]), 1007);
    check("d1_avg_p56", 32'(dut1.buf_q[56]), 1007);
    check("d1_p38", 32'(dut1.buf_q[38]), 998);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
